// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the data-memory stage state encoding.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH-byte data memory with one 8-byte little-endian port: synchronous write,
// combinational read. Byte addr+i maps to data bits [8i+7:8i].
module dmem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic          unused_addr_hi;

  // Only the low address bits select a byte; range checking happens upstream.
  assign idx            = addr[AW-1:0];
  assign unused_addr_hi = ^addr[63:AW];

  // Assemble the 8-byte little-endian read word.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  // Store all 8 bytes of the write word on the enabled edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_stage.sv
// Y86-64 data-memory stage: icode decode, range (and optional alignment) check,
// wait-state FSM and valid/ready handshake around dmem_array.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (unaligned accesses become errors).
module dmem_stage
  import y86_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valA,
  input  logic [ADDR_W-1:0] valE,
  input  logic [63:0]       valP,
  output logic              resp_valid,
  output logic [63:0]       valM,
  output logic              dmem_error,
  output logic              busy
);

  localparam logic [3:0]        LAT4     = 4'(LATENCY);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 8);

  dmem_state_t       st;
  logic [3:0]        cnt;
  logic              rd_in, wr_in, err_in;
  logic [ADDR_W-1:0] addr_in;
  logic [63:0]       wdata_in;
  logic              rd_q, wr_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata;
  logic              we;

  // Decode the presented instruction into access kind, address and write data.
  always_comb begin
    rd_in    = 1'b0;
    wr_in    = 1'b0;
    addr_in  = valE;
    wdata_in = 64'(valA);
    case (icode)
      ICODE_RMMOVQ, ICODE_PUSHQ: wr_in = 1'b1;
      ICODE_CALL: begin
        wr_in    = 1'b1;
        wdata_in = valP;
      end
      ICODE_MRMOVQ: rd_in = 1'b1;
      ICODE_RET, ICODE_POPQ: begin
        rd_in   = 1'b1;
        addr_in = valA;
      end
      default: ;
    endcase
  end

  // Flag accesses that would run past the end of memory (full-width compare, no wrap).
  always_comb begin
    err_in = (rd_in || wr_in) && (addr_in > MAX_ADDR);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((rd_in || wr_in) && (addr_in[2:0] != 3'b000)) err_in = 1'b1;
`else
    err_in = err_in;
`endif
  end

  assign we = (st == ST_ACCESS) && wr_q && !err_q;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (64'(addr_q)),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  // Request FSM with registered handshake and response outputs.
  // No-ops pass through ACCESS without touching memory so that their response
  // lands one cycle after acceptance, matching a zero-latency memory op.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      valM       <= '0;
      dmem_error <= 1'b0;
      busy       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            rd_q      <= rd_in;
            wr_q      <= wr_in;
            err_q     <= err_in;
            addr_q    <= addr_in;
            wdata_q   <= wdata_in;
            cnt       <= LAT4;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if ((rd_in || wr_in) && (LATENCY != 0)) st <= ST_WAIT;
            else                                    st <= ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (cnt <= 4'd1) st <= ST_ACCESS;
          else             cnt <= cnt - 4'd1;
        end
        ST_ACCESS: begin
          valM       <= (rd_q && !err_q) ? rdata : '0;
          dmem_error <= err_q;
          resp_valid <= 1'b1;
          busy       <= 1'b0;
          st         <= ST_RESP;
        end
        ST_RESP: begin
          valM       <= '0;
          dmem_error <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          st         <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// Directed bench for dmem_stage: one LATENCY=1 and one LATENCY=4 instance, DEPTH=1024.
module tb_dmem_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv1, rv4;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        rr1, rsp1, err1, busy1;
  logic        rr4, rsp4, err4, busy4;
  logic [63:0] vm1, vm4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_stage #(.DEPTH(1024), .LATENCY(1), .ADDR_W(64)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP), .resp_valid(rsp1), .valM(vm1),
    .dmem_error(err1), .busy(busy1)
  );

  dmem_stage #(.DEPTH(1024), .LATENCY(4), .ADDR_W(64)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rr4), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP), .resp_valid(rsp4), .valM(vm4),
    .dmem_error(err4), .busy(busy4)
  );

  // Issue one request to the selected instance, scramble the operands after
  // acceptance, and wait (bounded) for its response. lat counts negedges after
  // the accepting edge; -1 means no response arrived.
  task automatic txn(input int sel, input logic [3:0] ic, input logic [63:0] a,
                     input logic [63:0] e, input logic [63:0] p,
                     output int lat, output logic [63:0] vm, output logic er);
    int n;
    @(negedge clk);
    icode = ic; valA = a; valE = e; valP = p;
    if (sel == 0) rv1 = 1'b1; else rv4 = 1'b1;
    @(posedge clk);
    #1;
    rv1 = 1'b0; rv4 = 1'b0;
    icode = ICODE_NOP; valA = ~a; valE = ~e; valP = ~p;
    n = 0;
    @(negedge clk);
    while (((sel == 0) ? rsp1 : rsp4) !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    lat = (n >= 40) ? -1 : n;
    vm  = (sel == 0) ? vm1 : vm4;
    er  = (sel == 0) ? err1 : err4;
  endtask

  task automatic test_reset();
    checks++; if (rr1 !== 1'b1)  begin errors++; $display("FAIL reset_ready1: got %b want 1", rr1); end
    checks++; if (rsp1 !== 1'b0) begin errors++; $display("FAIL reset_resp1: got %b want 0", rsp1); end
    checks++; if (vm1 !== 64'd0) begin errors++; $display("FAIL reset_valM1: got %0h want 0", vm1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1: got %b want 0", err1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    checks++; if (rr4 !== 1'b1)  begin errors++; $display("FAIL reset_ready4: got %b want 1", rr4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
  endtask

  task automatic test_rw();
    int lat; logic [63:0] vm; logic er;
    txn(0, ICODE_RMMOVQ, 64'd1000, 64'd100, 64'd0, lat, vm, er);
    checks++; if (lat !== 2)     begin errors++; $display("FAIL rmmovq_lat: got %0d want 2", lat); end
    checks++; if (er !== 1'b0)   begin errors++; $display("FAIL rmmovq_err: got %b want 0", er); end
    checks++; if (vm !== 64'd0)  begin errors++; $display("FAIL rmmovq_valM: got %0h want 0", vm); end
    txn(0, ICODE_MRMOVQ, 64'd0, 64'd100, 64'd0, lat, vm, er);
    checks++; if (lat !== 2)       begin errors++; $display("FAIL mrmovq_lat: got %0d want 2", lat); end
    checks++; if (vm !== 64'd1000) begin errors++; $display("FAIL mrmovq_valM: got %0d want 1000", vm); end
    checks++; if (er !== 1'b0)     begin errors++; $display("FAIL mrmovq_err: got %b want 0", er); end
    @(negedge clk);
    checks++; if (rsp1 !== 1'b0 || rr1 !== 1'b1) begin errors++; $display("FAIL after_resp: got resp=%b ready=%b want 0/1", rsp1, rr1); end
  endtask

  task automatic test_call_ret();
    int lat; logic [63:0] vm; logic er;
    txn(0, ICODE_CALL, 64'd7, 64'd200, 64'd2000, lat, vm, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL call_err: got %b want 0", er); end
    txn(0, ICODE_POPQ, 64'd200, 64'd999, 64'd0, lat, vm, er);
    checks++; if (vm !== 64'd2000) begin errors++; $display("FAIL popq_valM: got %0d want 2000", vm); end
    txn(0, ICODE_PUSHQ, 64'd420, 64'd64, 64'd0, lat, vm, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL pushq_err: got %b want 0", er); end
    txn(0, ICODE_RET, 64'd64, 64'd500, 64'd0, lat, vm, er);
    checks++; if (vm !== 64'd420) begin errors++; $display("FAIL ret_valM: got %0d want 420", vm); end
    checks++; if (lat !== 2)      begin errors++; $display("FAIL ret_lat: got %0d want 2", lat); end
  endtask

  task automatic test_range();
    int lat; logic [63:0] vm; logic er;
    txn(0, ICODE_RMMOVQ, 64'h1122334455667788, 64'd1016, 64'd0, lat, vm, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr1016_err: got %b want 0", er); end
    txn(0, ICODE_RMMOVQ, 64'hDEADBEEFDEADBEEF, 64'd1017, 64'd0, lat, vm, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr1017_err: got %b want 1", er); end
    checks++; if (lat !== 2)   begin errors++; $display("FAIL wr1017_lat: got %0d want 2", lat); end
    txn(0, ICODE_MRMOVQ, 64'd0, 64'd1016, 64'd0, lat, vm, er);
    checks++; if (vm !== 64'h1122334455667788) begin errors++; $display("FAIL rd1016_valM: got %0h want 1122334455667788", vm); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd1016_err: got %b want 0", er); end
    txn(0, ICODE_RMMOVQ, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, lat, vm, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b want 1", er); end
    txn(0, ICODE_MRMOVQ, 64'd0, 64'h0000_0001_0000_0000, 64'd0, lat, vm, er);
    checks++; if (er !== 1'b1)  begin errors++; $display("FAIL hi_addr_err: got %b want 1", er); end
    checks++; if (vm !== 64'd0) begin errors++; $display("FAIL hi_addr_valM: got %0h want 0", vm); end
    @(negedge clk);
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err1); end
  endtask

  task automatic test_align();
    int lat; logic [63:0] vm; logic er;
    logic [63:0] exp_vm; logic exp_er;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_vm = 64'd0; exp_er = 1'b1;
`else
    exp_vm = 64'h6C6B6A6968676665; exp_er = 1'b0;
`endif
    txn(0, ICODE_RMMOVQ, 64'h6766656463626160, 64'd96, 64'd0, lat, vm, er);
    txn(0, ICODE_RMMOVQ, 64'h6F6E6D6C6B6A6968, 64'd104, 64'd0, lat, vm, er);
    txn(0, ICODE_MRMOVQ, 64'd0, 64'd101, 64'd0, lat, vm, er);
    checks++; if (vm !== exp_vm) begin errors++; $display("FAIL unaligned_valM: got %0h want %0h", vm, exp_vm); end
    checks++; if (er !== exp_er) begin errors++; $display("FAIL unaligned_err: got %b want %b", er, exp_er); end
    checks++; if (lat !== 2)     begin errors++; $display("FAIL unaligned_lat: got %0d want 2", lat); end
  endtask

  task automatic test_back_to_back();
    int lat; int n; int pulses; logic [63:0] vm; logic er;
    @(negedge clk);
    icode = ICODE_RMMOVQ; valA = 64'hAAAA_5555_1234_0001; valE = 64'd300; rv4 = 1'b1;
    @(posedge clk);
    #1;
    icode = ICODE_MRMOVQ; valA = 64'd0; valE = 64'd300;
    n = 0; pulses = 0;
    @(negedge clk);
    while (rr4 !== 1'b1 && n < 40) begin
      if (rsp4 === 1'b1) pulses++;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 6)      begin errors++; $display("FAIL ready_low_cycles: got %0d want 6", n); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL first_resp_pulses: got %0d want 1", pulses); end
    @(posedge clk);
    #1;
    rv4 = 1'b0; icode = ICODE_NOP; valE = 64'd0;
    n = 0;
    @(negedge clk);
    while (rsp4 !== 1'b1 && n < 40) begin n++; @(negedge clk); end
    checks++; if (n !== 5)                      begin errors++; $display("FAIL second_lat: got %0d want 5", n); end
    checks++; if (vm4 !== 64'hAAAA_5555_1234_0001) begin errors++; $display("FAIL second_valM: got %0h want aaaa555512340001", vm4); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp4 === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL double_accept: got %0d extra responses want 0", pulses); end
    txn(1, ICODE_HALT, 64'd1, 64'd2, 64'd3, lat, vm, er);
    checks++; if (lat !== 1)    begin errors++; $display("FAIL halt_lat: got %0d want 1", lat); end
    checks++; if (vm !== 64'd0) begin errors++; $display("FAIL halt_valM: got %0h want 0", vm); end
    txn(1, ICODE_NOP, 64'd100, 64'd300, 64'd3, lat, vm, er);
    checks++; if (lat !== 1)    begin errors++; $display("FAIL nop_lat: got %0d want 1", lat); end
    checks++; if (vm !== 64'd0 || er !== 1'b0) begin errors++; $display("FAIL nop_resp: got valM=%0h err=%b want 0/0", vm, er); end
  endtask

  task automatic test_reset_abort();
    int lat; int pulses; logic [63:0] vm; logic er;
    txn(1, ICODE_RMMOVQ, 64'h0123_4567_89AB_CDEF, 64'd300, 64'd0, lat, vm, er);
    checks++; if (lat !== 5) begin errors++; $display("FAIL l4_write_lat: got %0d want 5", lat); end
    @(negedge clk);
    icode = ICODE_RMMOVQ; valA = 64'hFEED_FACE_CAFE_BEEF; valE = 64'd300; rv4 = 1'b1;
    @(posedge clk);
    #1;
    rv4 = 1'b0;
    @(negedge clk);
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL busy_in_wait: got %b want 1", busy4); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rr4 !== 1'b1 || rsp4 !== 1'b0 || vm4 !== 64'd0 || err4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: got ready=%b resp=%b valM=%0h err=%b busy=%b want 1/0/0/0/0", rr4, rsp4, vm4, err4, busy4);
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp4 === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_resp: got %0d responses want 0", pulses); end
    txn(1, ICODE_MRMOVQ, 64'd0, 64'd300, 64'd0, lat, vm, er);
    checks++; if (vm !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL abort_old_data: got %0h want 0123456789abcdef", vm); end
  endtask

  initial begin
    rst = 1'b1; rv1 = 1'b0; rv4 = 1'b0;
    icode = ICODE_NOP; valA = '0; valE = '0; valP = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_rw();
    test_call_ret();
    test_range();
    test_align();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
